step_clock_gen: RTL and testbench

STEP_CLOCK_GEN -- requirements
Module: step_clock_gen

---
 rtl/step_clock_gen.sv | 169 ++++++++++++++++
 tb/tb_step_clock_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// step_clock_gen -- single-step / free-run clock generator for the pipeline CPU.
//
// A debounced push-button issues one cpu_clock pulse per press in single-step
// mode. In free-run mode a divider issues one pulse every RUN_DIV clocks. Each
// pulse is HALF_CYCLES high followed by at least HALF_CYCLES low. One step
// press arriving mid-pulse is remembered and replayed once the pulse ends.
//
// Ports:
//   clock       in   board clock
//   reset       in   synchronous, active-high
//   step_button in   raw push-button, 1 = pressed (asynchronous)
//   run_mode    in   raw switch, 1 = free-run, 0 = single-step (asynchronous)
//   cpu_clock   out  generated CPU clock, high only during the HIGH phase
//   busy        out  high for the whole pulse (HIGH and LOW phases)
//   step_count  out  number of pulses issued, wraps at 16 bits
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000,
  parameter int HALF_CYCLES     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_button,
  input  logic        run_mode,
  output logic        cpu_clock,
  output logic        busy,
  output logic [15:0] step_count
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(RUN_DIV + 1);
  localparam int PH_W  = $clog2(HALF_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic btn_s1, btn_s2, run_s1, run_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
    end else begin
      btn_s1 <= step_button;
      btn_s2 <= btn_s1;
      run_s1 <= run_mode;
      run_s2 <= run_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: btn_stable follows btn_s2 only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples. Any agreeing sample restarts the count.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic            btn_stable, btn_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt     <= '0;
      btn_stable <= 1'b0;
      btn_prev   <= 1'b0;
    end else begin
      btn_prev <= btn_stable;
      if (btn_s2 == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= btn_s2;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Rising edge of the debounced level; ignored in free-run mode.
  logic step_req;
  assign step_req = btn_stable & ~btn_prev & ~run_s2;

  // ---------------------------------------------------------------------------
  // Free-run divider. run_prev lets any mode change restart the period so the
  // first free-run pulse comes a full RUN_DIV after the switch settles.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             run_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      run_prev <= 1'b0;
    end else begin
      run_prev <= run_s2;
      if ((run_s2 != run_prev) || !run_s2) begin
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  logic run_req;
  assign run_req = run_s2 & run_prev & (div_cnt == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Pulse FSM. Only step requests can become pending; free-run requests that
  // land mid-pulse are simply lost (the next period will come along).
  // ---------------------------------------------------------------------------
  logic [1:0]      state;
  logic [PH_W-1:0] ph_cnt;
  logic            pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ph_cnt     <= '0;
      pending    <= 1'b0;
      step_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (step_req || run_req || pending) begin
            state      <= S_HIGH;
            ph_cnt     <= '0;
            pending    <= 1'b0;
            step_count <= step_count + 16'd1;
          end
        end
        S_HIGH: begin
          if (step_req) pending <= 1'b1;
          if (ph_cnt == PH_LAST) begin
            state  <= S_LOW;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (step_req) pending <= 1'b1;
          if (ph_cnt == PH_LAST) begin
            state  <= S_IDLE;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          ph_cnt <= '0;
        end
      endcase
    end
  end

  assign cpu_clock = (state == S_HIGH);
  assign busy      = (state == S_HIGH) || (state == S_LOW);

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: directed scenarios, a table of press/gap vectors,
// and a long randomized run against a reference model built from the block's
// rules (2-cycle synchronizer delay, D-sample debounce window, free-run period
// measured from the settled mode change, pulse windows and one-deep pending).
module tb_step_clock_gen;

  localparam int D  = 4;
  localparam int R  = 10;
  localparam int H1 = 2;
  localparam int H2 = 16;
  localparam int NR = 3000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step_button = 1'b0, run_mode = 1'b0;
  logic        step_button2 = 1'b0, run_mode2 = 1'b0;
  logic        cpu_clock, busy, cpu_clock2, busy2;
  logic [15:0] step_count, step_count2;

  step_clock_gen #(.DEBOUNCE_CYCLES(D), .RUN_DIV(R), .HALF_CYCLES(H1)) u_dut (
    .clock(clock), .reset(reset), .step_button(step_button), .run_mode(run_mode),
    .cpu_clock(cpu_clock), .busy(busy), .step_count(step_count));

  // Longer pulse so a full release/press cycle fits inside one busy window.
  step_clock_gen #(.DEBOUNCE_CYCLES(D), .RUN_DIV(R), .HALF_CYCLES(H2)) u_dut2 (
    .clock(clock), .reset(reset), .step_button(step_button2), .run_mode(run_mode2),
    .cpu_clock(cpu_clock2), .busy(busy2), .step_count(step_count2));

  always #5 clock = ~clock;

  int   checks = 0, errors = 0;
  int   cyc_n = 0, rises = 0, hi_cyc = 0, busy_cyc = 0, rise_at = 0, rises2 = 0;
  int   rise2_q[$];
  logic cpu_prev = 1'b0, cpu2_prev = 1'b0;

  typedef struct { int press; int gap; int pulses; } vec_t;
  vec_t vecs[6];

  // reference model state
  bit          b_in[NR];
  bit          r_in[NR];
  int          m_go, m_rstart;
  bit          m_stable, m_stable_prev, m_pend;
  logic [15:0] m_count;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // advance to the next negedge and update the edge/phase monitors
  task automatic cyc();
    @(negedge clock);
    cyc_n++;
    if (cpu_clock === 1'b1 && cpu_prev !== 1'b1) begin rises++; rise_at = cyc_n; end
    if (cpu_clock === 1'b1) hi_cyc++;
    if (busy === 1'b1) busy_cyc++;
    cpu_prev = cpu_clock;
    if (cpu_clock2 === 1'b1 && cpu2_prev !== 1'b1) begin rises2++; rise2_q.push_back(cyc_n); end
    cpu2_prev = cpu_clock2;
  endtask

  task automatic do_reset();
    reset = 1'b1; step_button = 1'b0; run_mode = 1'b0; step_button2 = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
  endtask

  task automatic drive_btn(input bit v, input int n);
    step_button = v;
    repeat (n) cyc();
  endtask

  task automatic drive_btn2(input bit v, input int n);
    step_button2 = v;
    repeat (n) cyc();
  endtask

  function automatic bit bsync(input int k);
    return (k >= 2) ? b_in[k-2] : 1'b0;
  endfunction

  function automatic bit rsync(input int k);
    return (k >= 2) ? r_in[k-2] : 1'b0;
  endfunction

  // Model one cycle k: which request fires, what the pulse window becomes,
  // and where the debounced level sits next cycle.
  task automatic model_step(input int k);
    bit rn, rp, stp, runr, bsy, all_diff;
    rn = rsync(k);
    rp = rsync(k-1);
    if (rn && !rp) m_rstart = k;
    stp  = m_stable && !m_stable_prev && !rn;
    runr = rn && rp && ((k - m_rstart) % R == 0);
    bsy  = (k > m_go) && (k <= m_go + 2*H1);
    if (!bsy) begin
      if (stp || runr || m_pend) begin
        m_go = k; m_pend = 1'b0; m_count = m_count + 16'd1;
      end
    end else if (stp) begin
      m_pend = 1'b1;
    end
    all_diff = 1'b1;
    for (int j = k - D + 1; j <= k; j++)
      if (bsync(j) == m_stable) all_diff = 1'b0;
    m_stable_prev = m_stable;
    if (all_diff) m_stable = bsync(k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, h, exp_total, bh, rh;
    bit bv, rv, e_cpu, e_busy, done;

    vecs[0] = '{10, 20, 1};
    vecs[1] = '{3,  20, 0};
    vecs[2] = '{4,  20, 1};
    vecs[3] = '{1,  20, 0};
    vecs[4] = '{6,  20, 1};
    vecs[5] = '{30, 20, 1};

    // reset values
    do_reset();
    check("rst_cpu_clock",  int'(cpu_clock), 0);
    check("rst_busy",       int'(busy), 0);
    check("rst_step_count", int'(step_count), 0);
    check("rst2_cpu_clock", int'(cpu_clock2), 0);
    check("rst2_busy",      int'(busy2), 0);

    // single step: 2 sync + 4 debounce + 1 request-to-high = rise 7 cycles after press
    rises = 0; hi_cyc = 0; busy_cyc = 0; n0 = cyc_n;
    drive_btn(1, 10);
    drive_btn(0, 30);
    check("single_pulses",  rises, 1);
    check("single_latency", rise_at - n0, 7);
    check("single_high",    hi_cyc, H1);
    check("single_busy",    busy_cyc, 2*H1);
    check("single_count",   int'(step_count), 1);

    // bounce: no press lasts DEBOUNCE_CYCLES
    rises = 0;
    drive_btn(1, 3); drive_btn(0, 2); drive_btn(1, 3); drive_btn(0, 20);
    check("bounce_pulses", rises, 0);
    check("bounce_count",  int'(step_count), 1);

    // table of press/gap vectors
    do_reset();
    exp_total = 0;
    for (int i = 0; i < 6; i++) begin
      rises = 0;
      drive_btn(1, vecs[i].press);
      drive_btn(0, vecs[i].gap);
      exp_total += vecs[i].pulses;
      check($sformatf("vec%0d_pulses", i), rises, vecs[i].pulses);
      check($sformatf("vec%0d_count", i), int'(step_count), exp_total);
    end

    // pending (long-pulse instance): 2nd press pends, 3rd dropped
    do_reset();
    rises2 = 0; rise2_q.delete();
    step_button2 = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if (rises2 > 0) done = 1'b1;
    end
    check("pend_first_seen", int'(done), 1);
    h = (rise2_q.size() > 0) ? rise2_q[0] : cyc_n;
    drive_btn2(0, 5); drive_btn2(1, 5); drive_btn2(0, 5); drive_btn2(1, 5); drive_btn2(0, 60);
    check("pend_pulses", rises2, 2);
    check("pend_gap", (rise2_q.size() > 1) ? rise2_q[1] - h : -1, 2*H2 + 1);
    check("pend_count", int'(step_count2), 2);

    // free-run for 100 cycles with button activity that must be ignored
    do_reset();
    rises = 0;
    run_mode = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step_button = ((i / 7) % 2 == 0);
      cyc();
    end
    run_mode = 1'b0; step_button = 1'b0;
    repeat (30) cyc();
    check("run_pulses", rises, 9);
    check("run_count",  int'(step_count), 9);

    // reset while cpu_clock is high
    do_reset();
    rises = 0;
    step_button = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      cyc();
      if (rises > 0) done = 1'b1;
    end
    check("midrst_high_seen", int'(done), 1);
    reset = 1'b1; step_button = 1'b0;
    cyc();
    check("midrst_cpu_clock",  int'(cpu_clock), 0);
    check("midrst_busy",       int'(busy), 0);
    check("midrst_step_count", int'(step_count), 0);
    reset = 1'b0; rises = 0; hi_cyc = 0;
    repeat (15) cyc();
    check("midrst_no_resume", hi_cyc, 0);
    check("midrst_count_after", int'(step_count), 0);

    // counter wrap
    do_reset();
    force u_dut.step_count = 16'hFFFF;
    cyc();
    release u_dut.step_count;
    cyc();
    check("wrap_preload", int'(step_count), 16'hFFFF);
    drive_btn(1, 10);
    drive_btn(0, 20);
    check("wrap_count", int'(step_count), 0);

    // randomized run against the reference model
    do_reset();
    m_go = -1000; m_rstart = 0; m_stable = 1'b0; m_stable_prev = 1'b0;
    m_pend = 1'b0; m_count = 16'd0;
    bh = 0; rh = 40; bv = 1'b0; rv = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (k > 0) cyc();
      e_cpu  = (k > m_go) && (k <= m_go + H1);
      e_busy = (k > m_go) && (k <= m_go + 2*H1);
      check($sformatf("random@%0d", k), int'({cpu_clock, busy, step_count}),
            int'({e_cpu, e_busy, m_count}));
      if (bh == 0) begin bv = !bv; bh = $urandom_range(1, 12); end
      bh--;
      if (rh == 0) begin rv = !rv; rh = $urandom_range(15, 120); end
      rh--;
      b_in[k] = bv; r_in[k] = rv;
      step_button = bv; run_mode = rv;
      model_step(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
